// File: rtl/ibr128_block_ctrl.sv
// Block sequencer for the IBR128 encrypt core: captures one block, starts the
// core, waits for a fresh completion (or times out) and holds the result downstream.
module ibr128_block_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_sa,
    input  logic         in_encrypt,
    output logic         encrypt,
    output logic         block_start,
    output logic [127:0] pData,
    output logic         sa,
    input  logic         block_ready,
    input  logic [127:0] eData,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_err,
    output logic         busy,
    output logic [15:0]  blocks_done
);

    // state | meaning
    // IDLE  | waiting for an upstream block, in_ready high
    // START | one-cycle block_start pulse to the core
    // WAIT  | core running; arm on first low block_ready, then complete or time out
    // HOLD  | result presented until downstream accepts it
    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        armed;
    logic [15:0] tcnt;

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            block_start <= 1'b0;
            pData       <= '0;
            sa          <= 1'b0;
            encrypt     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
            busy        <= 1'b0;
            blocks_done <= '0;
            armed       <= 1'b0;
            tcnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pData       <= in_data;
                        sa          <= in_sa;
                        encrypt     <= in_encrypt;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        block_start <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    block_start <= 1'b0;
                    armed       <= 1'b0;
                    tcnt        <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    // A ready seen before the first low cycle belongs to the previous block.
                    if (armed && block_ready) begin
                        out_data    <= eData;
                        out_err     <= 1'b0;
                        out_valid   <= 1'b1;
                        blocks_done <= blocks_done + 16'd1;
                        state       <= HOLD;
                    end else if (tcnt == TLAST) begin
                        out_data  <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                        if (!block_ready) begin
                            armed <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibr128_block_ctrl.sv
// Directed bench for ibr128_block_ctrl: one instance with the default timeout and
// one with an 8-cycle timeout, driven from a table of blocks plus a reset sequence.
module tb_ibr128_block_ctrl;

    logic         Clk = 1'b0;
    logic         RstN = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_sa = 1'b0;
    logic         in_encrypt = 1'b0;
    logic         block_ready = 1'b0;
    logic [127:0] eData = '0;
    logic         out_ready = 1'b0;
    logic         sel = 1'b0;

    logic         in_ready_m, block_start_m, sa_m, encrypt_m, out_valid_m, out_err_m, busy_m;
    logic [127:0] pData_m, out_data_m;
    logic [15:0]  blocks_done_m;
    logic         in_ready_t, block_start_t, sa_t, encrypt_t, out_valid_t, out_err_t, busy_t;
    logic [127:0] pData_t, out_data_t;
    logic [15:0]  blocks_done_t;

    always #5 Clk = ~Clk;

    ibr128_block_ctrl dut_m (
        .Clk(Clk), .RstN(RstN), .in_valid(in_valid & ~sel), .in_ready(in_ready_m),
        .in_data(in_data), .in_sa(in_sa), .in_encrypt(in_encrypt), .encrypt(encrypt_m),
        .block_start(block_start_m), .pData(pData_m), .sa(sa_m), .block_ready(block_ready),
        .eData(eData), .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
        .out_err(out_err_m), .busy(busy_m), .blocks_done(blocks_done_m)
    );

    ibr128_block_ctrl #(.TIMEOUT_CYCLES(8)) dut_t (
        .Clk(Clk), .RstN(RstN), .in_valid(in_valid & sel), .in_ready(in_ready_t),
        .in_data(in_data), .in_sa(in_sa), .in_encrypt(in_encrypt), .encrypt(encrypt_t),
        .block_start(block_start_t), .pData(pData_t), .sa(sa_t), .block_ready(block_ready),
        .eData(eData), .out_valid(out_valid_t), .out_ready(out_ready), .out_data(out_data_t),
        .out_err(out_err_t), .busy(busy_t), .blocks_done(blocks_done_t)
    );

    wire         o_in_ready    = sel ? in_ready_t    : in_ready_m;
    wire         o_block_start = sel ? block_start_t : block_start_m;
    wire         o_sa          = sel ? sa_t          : sa_m;
    wire         o_encrypt     = sel ? encrypt_t     : encrypt_m;
    wire         o_out_valid   = sel ? out_valid_t   : out_valid_m;
    wire         o_out_err     = sel ? out_err_t     : out_err_m;
    wire         o_busy        = sel ? busy_t        : busy_m;
    wire [127:0] o_pData       = sel ? pData_t       : pData_m;
    wire [127:0] o_out_data    = sel ? out_data_t    : out_data_m;
    wire [15:0]  o_blocks_done = sel ? blocks_done_t : blocks_done_m;

    localparam logic [127:0] STALE = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    typedef struct {
        logic         tsel;
        logic         sa;
        logic         enc;
        logic [127:0] data;
        int           stale_end;   // core ready driven high for c < stale_end
        int           rdy_at;      // core ready driven high (new eData) for c >= rdy_at
        logic [127:0] edata;
        int           hold;
        int           exp_c;       // cycle after handshake at which out_valid is first seen
        logic         exp_err;
        logic [127:0] exp_out;
        logic [15:0]  exp_blocks;
    } vec_t;

    vec_t vecs[7];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_block(input vec_t v);
        int got;
        sel        = v.tsel;
        out_ready  = 1'b0;
        in_data    = v.data;
        in_sa      = v.sa;
        in_encrypt = v.enc;
        in_valid   = 1'b1;
        chk("in_ready_idle", 128'(o_in_ready), 128'(1'b1));
        @(posedge Clk); #1;
        in_valid   = 1'b0;
        in_data    = ~v.data;
        in_sa      = ~v.sa;
        in_encrypt = ~v.enc;
        chk("start_pulse", 128'(o_block_start), 128'(1'b1));
        chk("busy_start", 128'(o_busy), 128'(1'b1));
        chk("in_ready_start", 128'(o_in_ready), 128'(1'b0));
        chk("sa_cap", 128'(o_sa), 128'(v.sa));
        chk("enc_cap", 128'(o_encrypt), 128'(v.enc));
        chk("pdata_cap", o_pData, v.data);
        block_ready = (0 < v.stale_end);
        eData       = STALE;
        got = 0;
        for (int c = 1; c <= 60 && got == 0; c++) begin
            @(posedge Clk); #1;
            if (o_out_valid) begin
                got = c;
            end else begin
                chk("start_single", 128'(o_block_start), 128'(1'b0));
                chk("pdata_stable", o_pData, v.data);
                block_ready = (c < v.stale_end) || (c >= v.rdy_at);
                eData       = (c >= v.rdy_at) ? v.edata : STALE;
            end
        end
        chk("latency", 128'(got), 128'(v.exp_c));
        chk("out_err", 128'(o_out_err), 128'(v.exp_err));
        chk("out_data", o_out_data, v.exp_out);
        chk("blocks_done", 128'(o_blocks_done), 128'(v.exp_blocks));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge Clk); #1;
            chk("hold_valid", 128'(o_out_valid), 128'(1'b1));
            chk("hold_data", o_out_data, v.exp_out);
            chk("hold_err", 128'(o_out_err), 128'(v.exp_err));
            chk("hold_in_ready", 128'(o_in_ready), 128'(1'b0));
            chk("hold_no_start", 128'(o_block_start), 128'(1'b0));
        end
        out_ready = 1'b1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        chk("release_valid", 128'(o_out_valid), 128'(1'b0));
        chk("release_in_ready", 128'(o_in_ready), 128'(1'b1));
        chk("release_busy", 128'(o_busy), 128'(1'b0));
    endtask

    initial begin
        //           tsel  sa    enc   data                                     stale rdy  edata                                    hold exp_c err   exp_out                                  blocks
        vecs[0] = '{1'b0, 1'b0, 1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 0,   17,  128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 0,   18,   1'b0, 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5, 16'd1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 128'h112233445566778899AABBCCDDEEFF00, 4,   9,   128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, 10,  10,   1'b0, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, 16'd2};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 128'hFEDCBA9876543210FEDCBA9876543210, 0,   2,   128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 0,   3,    1'b0, 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 16'd3};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 128'hCAFEBABE00000000CAFEBABE00000001, 0,   5,   128'h123456789ABCDEF0123456789ABCDEF0, 2,   6,    1'b0, 128'h123456789ABCDEF0123456789ABCDEF0, 16'd4};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 128'h00000000000000000000000000000042, 0,   100, 128'h77777777777777777777777777777777, 3,   9,    1'b1, 128'h0,                                16'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 128'h0000000000000000000000000000ABCD, 0,   8,   128'h3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C, 0,   9,    1'b0, 128'h3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C, 16'd1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 128'h0000000000000000000000000000BEEF, 0,   9,   128'h99999999999999999999999999999999, 0,   9,    1'b1, 128'h0,                                16'd1};

        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_in_ready", 128'(o_in_ready), 128'(1'b1));
            chk("rst_start", 128'(o_block_start), 128'(1'b0));
            chk("rst_valid", 128'(o_out_valid), 128'(1'b0));
            chk("rst_err", 128'(o_out_err), 128'(1'b0));
            chk("rst_busy", 128'(o_busy), 128'(1'b0));
            chk("rst_pdata", o_pData, 128'h0);
            chk("rst_out_data", o_out_data, 128'h0);
            chk("rst_sa_enc", 128'({o_sa, o_encrypt}), 128'(2'b00));
            chk("rst_blocks", 128'(o_blocks_done), 128'(16'd0));
        end
        sel = 1'b0;
        @(posedge Clk); #1;
        RstN = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_block(vecs[i]);
        end

        // Reset in the middle of WAIT on the default instance.
        sel         = 1'b0;
        in_data     = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;
        in_sa       = 1'b1;
        in_encrypt  = 1'b1;
        in_valid    = 1'b1;
        @(posedge Clk); #1;
        in_valid    = 1'b0;
        block_ready = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("midwait_busy", 128'(o_busy), 128'(1'b1));
        RstN = 1'b0;
        #1;
        chk("midrst_in_ready", 128'(o_in_ready), 128'(1'b1));
        chk("midrst_busy", 128'(o_busy), 128'(1'b0));
        chk("midrst_start", 128'(o_block_start), 128'(1'b0));
        chk("midrst_valid", 128'(o_out_valid), 128'(1'b0));
        chk("midrst_pdata", o_pData, 128'h0);
        chk("midrst_sa_enc", 128'({o_sa, o_encrypt}), 128'(2'b00));
        chk("midrst_blocks", 128'(o_blocks_done), 128'(16'd0));
        @(posedge Clk); #1;
        RstN = 1'b1;
        @(posedge Clk); #1;
        run_block(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
